// File: rtl/motor_step_scheduler_if.sv
// Move-request / step-pulse bundle between motion control and motor_step_scheduler.
// Position outputs exist only when STEP_POSITION_EN is defined.
interface motor_step_scheduler_if #(parameter int CNT_W = 16);
    logic       enable;
    logic [1:0] req_theta_pos, req_theta_neg, req_phi_pos, req_phi_neg;
    logic       step_theta, dir_theta, step_phi, dir_phi, busy, fault;
`ifdef STEP_POSITION_EN
    logic signed [CNT_W-1:0] pos_theta, pos_phi;

    modport master (
        output enable, req_theta_pos, req_theta_neg, req_phi_pos, req_phi_neg,
        input  step_theta, dir_theta, step_phi, dir_phi, busy, fault, pos_theta, pos_phi
    );
    modport slave (
        input  enable, req_theta_pos, req_theta_neg, req_phi_pos, req_phi_neg,
        output step_theta, dir_theta, step_phi, dir_phi, busy, fault, pos_theta, pos_phi
    );
`else
    modport master (
        output enable, req_theta_pos, req_theta_neg, req_phi_pos, req_phi_neg,
        input  step_theta, dir_theta, step_phi, dir_phi, busy, fault
    );
    modport slave (
        input  enable, req_theta_pos, req_theta_neg, req_phi_pos, req_phi_neg,
        output step_theta, dir_theta, step_phi, dir_phi, busy, fault
    );
`endif
endinterface

// File: rtl/motor_step_scheduler.sv
// Round-robin theta/phi step-pulse scheduler with reversal dead time and illegal-request fault.
// Define STEP_POSITION_EN to add signed per-axis step position counters.
module motor_step_scheduler #(
    parameter int STEP_HI_CYC = 50,
    parameter int STEP_LO_CYC = 50,
    parameter int DEAD_CYC    = 100,
    parameter int BURST       = 4,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    motor_step_scheduler_if.slave  bus
);
    localparam int AX = 2;  // axis index: 0 = theta, 1 = phi
    localparam logic [CNT_W-1:0] HI_LD   = CNT_W'(STEP_HI_CYC - 1);
    localparam logic [CNT_W-1:0] LO_LD   = CNT_W'(STEP_LO_CYC - 1);
    localparam logic [CNT_W-1:0] DEAD_LD = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

    typedef enum logic [1:0] {IDLE, SETTLE, STEP_HI, STEP_LO} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       timer, burst;
    logic                   last_axis, axis;
    logic [AX-1:0]          step_q, dir_q;
    logic                   fault_q;

    logic [AX-1:0][1:0]     req_pos, req_neg;
    logic [AX-1:0]          valid, illegal, want_dir;
    logic                   grant_go, grant_axis, cont, fire;

    assign req_pos = {bus.req_phi_pos, bus.req_theta_pos};
    assign req_neg = {bus.req_phi_neg, bus.req_theta_neg};

    // Only a single 2'b01 on one side is a move; anything else is idle, and codes with bit 1 set are illegal.
    for (genvar a = 0; a < AX; a++) begin : g_dec
        logic p, n;
        assign p           = (req_pos[a] == 2'b01);
        assign n           = (req_neg[a] == 2'b01);
        assign illegal[a]  = req_pos[a][1] | req_neg[a][1] | (p & n);
        assign valid[a]    = (p ^ n) & ~illegal[a];
        assign want_dir[a] = p;
    end

    always_comb begin
        grant_axis = last_axis;
        if (valid[0] && valid[1]) grant_axis = ~last_axis;
        else if (valid[0])        grant_axis = 1'b0;
        else if (valid[1])        grant_axis = 1'b1;
    end

    assign grant_go = bus.enable && (valid != '0);
    assign cont     = bus.enable && (burst < BURST_C) && valid[axis] && (want_dir[axis] == dir_q[axis]);

    // fire marks the edge on which a step pulse rises.
    always_comb begin
        fire = 1'b0;
        case (state)
            IDLE:    fire = grant_go && (dir_q[grant_axis] == want_dir[grant_axis]);
            SETTLE:  fire = (timer == '0);
            STEP_LO: fire = (timer == '0) && cont;
            default: fire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            timer     <= '0;
            burst     <= '0;
            last_axis <= 1'b1;
            axis      <= 1'b0;
            step_q    <= '0;
            dir_q     <= '0;
            fault_q   <= 1'b0;
        end else begin
            fault_q <= (state == IDLE) && (illegal != '0);
            case (state)
                IDLE: if (grant_go) begin
                    axis      <= grant_axis;
                    last_axis <= grant_axis;
                    burst     <= '0;
                    if (fire) begin
                        state              <= STEP_HI;
                        timer              <= HI_LD;
                        step_q[grant_axis] <= 1'b1;
                    end else begin
                        dir_q[grant_axis]  <= want_dir[grant_axis];
                        state              <= SETTLE;
                        timer              <= DEAD_LD;
                    end
                end
                SETTLE: if (fire) begin
                    state        <= STEP_HI;
                    timer        <= HI_LD;
                    step_q[axis] <= 1'b1;
                end else begin
                    timer <= timer - 1'b1;
                end
                STEP_HI: if (timer == '0) begin
                    state  <= STEP_LO;
                    timer  <= LO_LD;
                    step_q <= '0;
                    burst  <= burst + 1'b1;
                end else begin
                    timer <= timer - 1'b1;
                end
                STEP_LO: if (timer == '0) begin
                    if (fire) begin
                        state        <= STEP_HI;
                        timer        <= HI_LD;
                        step_q[axis] <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end else begin
                    timer <= timer - 1'b1;
                end
            endcase
        end
    end

    assign bus.step_theta = step_q[0];
    assign bus.step_phi   = step_q[1];
    assign bus.dir_theta  = dir_q[0];
    assign bus.dir_phi    = dir_q[1];
    assign bus.busy       = (state != IDLE);
    assign bus.fault      = fault_q;

`ifdef STEP_POSITION_EN
    logic                    fire_axis;
    logic signed [CNT_W-1:0] pos_q [AX];

    assign fire_axis = (state == IDLE) ? grant_axis : axis;

    // Direction is already settled whenever a pulse fires, so dir_q is the pulse direction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pos_q[0] <= '0;
            pos_q[1] <= '0;
        end else if (fire) begin
            if (dir_q[fire_axis]) pos_q[fire_axis] <= pos_q[fire_axis] + CNT_W'(1);
            else                  pos_q[fire_axis] <= pos_q[fire_axis] - CNT_W'(1);
        end
    end

    assign bus.pos_theta = pos_q[0];
    assign bus.pos_phi   = pos_q[1];
`endif
endmodule

// File: tb/tb_motor_step_scheduler.sv
// Directed bench for motor_step_scheduler: timing, arbitration, dead time, fault, reset.
module tb_motor_step_scheduler;
    logic clk = 1'b0;
    logic rst;
    int   n_tot = 0;
    int   n_bad = 0;
    logic overlap = 1'b0;
    logic dir_watch = 1'b0;
    logic dir_bad = 1'b0;

    motor_step_scheduler_if #(.CNT_W(16)) bus ();
    motor_step_scheduler dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.step_theta && bus.step_phi) overlap = 1'b1;
        if (dir_watch && (bus.dir_theta !== 1'b1 || bus.dir_phi !== 1'b0)) dir_bad = 1'b1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    function automatic logic stp(input int ax);
        return (ax == 0) ? bus.step_theta : bus.step_phi;
    endfunction

    task automatic wait_rise(input int ax, output int n);
        n = 0;
        while (!stp(ax)) begin
            if (n >= 400) begin n = -1; return; end
            tick(1); n++;
        end
    endtask

    task automatic hi_len(input int ax, output int n);
        n = 0;
        while (stp(ax)) begin
            if (n >= 400) begin n = -1; return; end
            tick(1); n++;
        end
    endtask

    task automatic clr_reqs();
        bus.req_theta_pos = 2'b00; bus.req_theta_neg = 2'b00;
        bus.req_phi_pos   = 2'b00; bus.req_phi_neg   = 2'b00;
    endtask

`ifdef STEP_POSITION_EN
    task automatic run_theta(input logic pos_dir, input int cnt);
        int n, k;
        if (pos_dir) bus.req_theta_pos = 2'b01; else bus.req_theta_neg = 2'b01;
        for (int i = 0; i < cnt; i++) begin
            wait_rise(0, n);
            chk("t6_rise", int'(n >= 0), 1);
            if (i == cnt - 1) clr_reqs();
            hi_len(0, n);
        end
        k = 0;
        while (bus.busy && k < 300) begin tick(1); k++; end
        chk("t6_idle", bus.busy, 0);
    endtask
`endif

    initial begin
        int n;
        rst = 1'b0; bus.enable = 1'b1;
        bus.req_theta_pos = 2'b01; bus.req_theta_neg = 2'b01;
        bus.req_phi_pos   = 2'b01; bus.req_phi_neg   = 2'b01;
        tick(3);
        chk("rst_step_t", bus.step_theta, 0);
        chk("rst_step_p", bus.step_phi, 0);
        chk("rst_dir_t", bus.dir_theta, 0);
        chk("rst_dir_p", bus.dir_phi, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_fault", bus.fault, 0);
        clr_reqs(); rst = 1'b1;
        tick(1);
        chk("idle_busy", bus.busy, 0);
        chk("idle_fault", bus.fault, 0);

        // theta pos from reset: reversal 0->1 needs dead time
        bus.req_theta_pos = 2'b01;
        tick(1);
        chk("t2_dir", bus.dir_theta, 1);
        chk("t2_busy", bus.busy, 1);
        chk("t2_settle_step", bus.step_theta, 0);
        wait_rise(0, n);
        chk("t2_settle_len", n, 100);
        for (int p = 0; p < 4; p++) begin
            hi_len(0, n);
            chk("t2_hi_len", n, 50);
            if (p < 3) begin
                wait_rise(0, n);
                chk("t2_lo_len", n, 50);
            end
        end
        tick(49);
        chk("t2_lo_busy", bus.busy, 1);
        tick(1);
        chk("t2_idle", bus.busy, 0);
        tick(1);
        chk("t2_rearm", bus.step_theta, 1);
        chk("t2_dir_hold", bus.dir_theta, 1);

        // withdraw at cycle 10 of the high phase
        tick(9);
        bus.req_theta_pos = 2'b00;
        hi_len(0, n);
        chk("t4_hi_total", 9 + n, 50);
        tick(49);
        chk("t4_lo_busy", bus.busy, 1);
        tick(1);
        chk("t4_idle", bus.busy, 0);
        tick(5);
        chk("t4_stay_idle", bus.busy, 0);
        chk("t4_no_step", bus.step_theta, 0);

        // both axes: theta was last, so phi wins first; dir_phi already 0 -> no settle
        bus.req_theta_pos = 2'b01; bus.req_phi_neg = 2'b01; dir_watch = 1'b1;
        wait_rise(1, n);
        chk("t3_phi_first", n, 1);
        for (int b = 0; b < 3; b++) begin
            for (int p = 0; p < 4; p++) begin
                if (!(b == 0 && p == 0)) begin
                    wait_rise((b % 2 == 0) ? 1 : 0, n);
                    chk("t3_gap", n, (p == 0) ? 51 : 50);
                end
                hi_len((b % 2 == 0) ? 1 : 0, n);
                chk("t3_hi_len", n, 50);
            end
        end
        clr_reqs();
        tick(60);
        dir_watch = 1'b0;
        chk("t3_idle", bus.busy, 0);
        chk("t3_overlap", overlap, 0);
        chk("t3_dir_stable", dir_bad, 0);

        // illegal requests
        bus.req_phi_pos = 2'b01; bus.req_phi_neg = 2'b01;
        tick(1);
        chk("t5_fault1", bus.fault, 1);
        tick(1);
        chk("t5_fault2", bus.fault, 1);
        chk("t5_busy", bus.busy, 0);
        chk("t5_no_phi", bus.step_phi, 0);
        clr_reqs(); bus.req_theta_pos = 2'b11;
        tick(1);
        chk("t5_fault_11", bus.fault, 1);
        chk("t5_busy_11", bus.busy, 0);
        clr_reqs();
        tick(1);
        chk("t5_fault_clr", bus.fault, 0);

        // enable low blocks grants; then reversal 1->0 with dead time
        bus.enable = 1'b0; bus.req_theta_neg = 2'b01;
        tick(5);
        chk("en_busy", bus.busy, 0);
        chk("en_dir_hold", bus.dir_theta, 1);
        bus.enable = 1'b1;
        tick(1);
        chk("rev_dir", bus.dir_theta, 0);
        chk("rev_step", bus.step_theta, 0);
        wait_rise(0, n);
        chk("rev_settle_len", n, 100);

        // reset mid-pulse drops step at the same edge
        tick(5);
        rst = 1'b0;
        tick(1);
        chk("mid_rst_step", bus.step_theta, 0);
        chk("mid_rst_busy", bus.busy, 0);
        rst = 1'b1; clr_reqs();
        tick(1);

`ifdef STEP_POSITION_EN
        chk("t6_pos_rst", bus.pos_theta, 0);
        run_theta(1'b1, 3);
        chk("t6_pos_up", bus.pos_theta, 3);
        run_theta(1'b0, 5);
        chk("t6_pos_final", bus.pos_theta, -2);
        chk("t6_pos_phi", bus.pos_phi, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
